// File: rtl/hit_scorer.sv
// Whack-a-mole hit scorer: debounced buttons, BCD score, lives and spawn pacing.
// Optional build macro MISS_PENALTY_EN: a press on an empty hole also costs a life.
module hit_scorer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SPAWN_GAP       = 50000000,
  parameter int START_LIVES     = 3
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  btn,
  input  logic [7:0]  mole,
  input  logic [1:0]  difficulty,
  output logic [7:0]  molehit,
  output logic        enable,
  output logic [15:0] score_bcd,
  output logic [2:0]  lives,
  output logic        game_over
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(SPAWN_GAP + 1);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  // Bit 0 is the start button, bits 8:1 are the hole buttons.
  logic [8:0] raw, sync1_reg, sync2_reg, level, level_prev_reg, press;
  assign raw   = {btn, start};
  assign press = level & ~level_prev_reg;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      level_prev_reg <= '0;
    end else begin
      sync1_reg      <= raw;
      sync2_reg      <= sync1_reg;
      level_prev_reg <= level;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_db
      logic [DB_W-1:0] cnt_reg;
      logic            level_reg;
      assign level[gi] = level_reg;
      // Counts consecutive samples that disagree with the accepted level.
      always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg   <= '0;
          level_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [2:0] inc);
    logic [4:0]  d;
    logic        carry;
    logic [15:0] r;
    carry = 1'b0;
    r     = '0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, a[4*k +: 4]} + ((k == 0) ? {2'b00, inc} : 5'd0) + {4'b0000, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      r[4*k +: 4] = d[3:0];
    end
    return carry ? 16'h9999 : r;
  endfunction

  state_t           state_reg;
  logic [7:0]       pending_reg, hit_mask_reg, mole_prev_reg, molehit_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [15:0]      score_reg;
  logic [2:0]       lives_reg, lives_next;
  logic             enable_reg, game_over_reg;

  logic [7:0] proc_bit, fall, escape, hit_bit;
  logic       lose_life;

  always_comb begin
    proc_bit  = pending_reg & (~pending_reg + 8'd1);
    fall      = mole_prev_reg & ~mole;
    escape    = fall & ~hit_mask_reg;
    hit_bit   = proc_bit & mole;
`ifdef MISS_PENALTY_EN
    lose_life = (|escape) | (|(proc_bit & ~mole));
`else
    lose_life = |escape;
`endif
    lives_next = (lose_life && lives_reg != 3'd0) ? lives_reg - 3'd1 : lives_reg;
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      hit_mask_reg  <= '0;
      mole_prev_reg <= '0;
      molehit_reg   <= '0;
      gap_cnt_reg   <= '0;
      score_reg     <= '0;
      lives_reg     <= '0;
      enable_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      mole_prev_reg <= mole;
      molehit_reg   <= '0;
      enable_reg    <= 1'b0;
      case (state_reg)
        PLAY: begin
          pending_reg  <= (pending_reg & ~proc_bit) | press[8:1];
          hit_mask_reg <= (hit_mask_reg & ~fall) | hit_bit;
          molehit_reg  <= hit_bit;
          lives_reg    <= lives_next;
          if (|hit_bit)
            score_reg <= bcd_add(score_reg, {1'b0, difficulty} + 3'd1);
          if (mole != 8'd0) begin
            gap_cnt_reg <= '0;
          end else if (gap_cnt_reg == GAP_W'(SPAWN_GAP - 1)) begin
            gap_cnt_reg <= '0;
            enable_reg  <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
          if (lives_next == 3'd0) begin
            state_reg     <= OVER;
            game_over_reg <= 1'b1;
          end
        end
        default: begin
          pending_reg <= '0;
          if (press[0]) begin
            state_reg     <= PLAY;
            game_over_reg <= 1'b0;
            score_reg     <= '0;
            lives_reg     <= 3'(START_LIVES);
            hit_mask_reg  <= '0;
            gap_cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

  assign molehit   = molehit_reg;
  assign enable    = enable_reg;
  assign score_bcd = score_reg;
  assign lives     = lives_reg;
  assign game_over = game_over_reg;
endmodule

// File: doc/hit_scorer.md
HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-level cycles before a button is accepted (10 ms at 100 MHz).
REQ-002 Parameter SPAWN_GAP, default 50000000, SHALL set the empty-board cycles before a spawn request.
REQ-003 Parameter START_LIVES, default 3, SHALL set the lives loaded on game start (range 1..7).
REQ-004 CLK100MHZ  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  in  1  SHALL be the raw start button (asynchronous, bouncy).
REQ-007 btn  in  8  SHALL be the raw hole buttons; bit i maps to hole i.
REQ-008 mole  in  8  SHALL be the one-hot-or-zero vector of raised moles from the mole picker.
REQ-009 difficulty  in  2  SHALL be the points-per-hit selector.
REQ-010 molehit  out  8  SHALL be the registered one-cycle hit pulse per hole, fed back to the mole picker.
REQ-011 enable  out  1  SHALL be the registered one-cycle spawn request to the mole picker.
REQ-012 score_bcd  out  16  SHALL be the 4-digit BCD score.
REQ-013 lives  out  3  SHALL be the remaining lives.
REQ-014 game_over  out  1  SHALL be high while in state OVER.

Function
REQ-015 start and each btn bit SHALL pass a 2-flop synchroniser, then a per-input debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A press event SHALL be a 0->1 transition of a debounced level; press events SHALL set the matching bit of an 8-bit pending register.
REQ-017 States SHALL be IDLE, PLAY, OVER; IDLE->PLAY and OVER->PLAY on a start press event; PLAY->OVER when lives reaches 0.
REQ-018 On entry to PLAY, score_bcd SHALL clear to 0, lives SHALL load START_LIVES, pending and hit_mask SHALL clear.
REQ-019 In PLAY, each cycle the lowest-index set pending bit i SHALL be cleared and processed; other pending bits wait.
REQ-020 If mole[i]=1 when processed, molehit[i] SHALL pulse the next cycle, hit_mask[i] SHALL set, and score SHALL add difficulty+1 points.
REQ-021 Score addition SHALL be BCD-correct with decimal carry and SHALL saturate at 9999.
REQ-022 hit_mask[i] SHALL clear on the falling edge of mole[i]; a falling edge with hit_mask[i]=0 SHALL be an escape.
REQ-023 Any escape(s) in a cycle SHALL decrement lives by exactly one, saturating at 0.
REQ-024 Escape and hit in the same cycle on different holes SHALL both take effect.
REQ-025 In PLAY, when mole==0 for SPAWN_GAP consecutive cycles, enable SHALL pulse one cycle and the gap counter SHALL restart; any nonzero mole resets the counter.
REQ-026 In IDLE and OVER, molehit and enable SHALL stay 0, pending SHALL be cleared, and score_bcd and lives SHALL hold.

Reset
REQ-027 reset SHALL force state IDLE, molehit=0, enable=0, score_bcd=0, lives=0, game_over=0, and clear pending, hit_mask, debouncers, and counters.
REQ-028 reset asserted mid-game SHALL abort immediately; no pending press SHALL be scored after release.

Configuration
REQ-029 With MISS_PENALTY_EN defined, a processed press with mole[i]=0 SHALL decrement lives by one (merged with any same-cycle escape into one decrement); without it, such presses SHALL be discarded silently.

Verification
REQ-030 Reset, start pressed and held >DEBOUNCE_CYCLES -> PLAY, lives=3, score_bcd=0x0000, game_over=0.
REQ-031 mole=0x04, btn[2] debounced press, difficulty=2 -> molehit=0x04 for one cycle, score_bcd=0x0003; mole then falls -> lives stays 3.
REQ-032 mole=0x10 falls to 0 with no press -> lives 3->2; three escapes -> lives=0, game_over=1, enable stays 0.
REQ-033 score_bcd=0x9998, hit with difficulty=3 -> score_bcd=0x9999; score_bcd=0x0097, difficulty=2 hit -> 0x0100.
REQ-034 btn[5] bouncing faster than DEBOUNCE_CYCLES then stable -> exactly one press event; with MISS_PENALTY_EN and mole=0 -> lives decrements once.
REQ-035 mole=0 held SPAWN_GAP cycles in PLAY -> enable one-cycle pulse, repeating every SPAWN_GAP cycles.
